// File: rtl/dru_align_ctrl.sv
// Restart/settle sequencer and K28.5 word aligner for a 2-bit-per-cycle DRU.
// Outputs are registered and lag their decision cycle by one clock. There is no backpressure: one word is emitted every 5 cycles.
module dru_align_ctrl #(
   parameter int unsigned HOLD_CYCLES   = 16,
   parameter int unsigned SETTLE_CYCLES = 64,
   parameter logic [9:0]  COMMA         = 10'b0011111010,
   parameter int unsigned LOCK_COMMAS   = 4,
   parameter int unsigned TIMEOUT       = 1024,
   parameter int unsigned WINDOW        = 256,
   parameter int unsigned MAX_JUMPS     = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic [1:0] dru_data,
   input  logic [1:0] dru_state,
   output logic       dru_aresetn,
   output logic [9:0] word,
   output logic       word_valid,
   output logic       locked,
   output logic       bit_offset,
   output logic [7:0] retry_count
);

   function automatic int unsigned umax(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

   localparam int unsigned MAXC = umax(umax(HOLD_CYCLES, SETTLE_CYCLES), umax(TIMEOUT, WINDOW));
   localparam int CW = $clog2(MAXC) + 1;
   localparam int KW = $clog2(LOCK_COMMAS + 1) + 1;
   localparam int JW = $clog2(MAX_JUMPS + 2) + 1;

   localparam logic [CW-1:0] HOLD_END   = CW'(HOLD_CYCLES - 1);
   localparam logic [CW-1:0] SETTLE_END = CW'(SETTLE_CYCLES - 1);
   localparam logic [CW-1:0] TMO_END    = CW'(TIMEOUT - 1);
   localparam logic [CW-1:0] WIN_END    = CW'(WINDOW - 1);
   localparam logic [KW-1:0] LOCK_N     = KW'(LOCK_COMMAS);
   localparam logic [JW-1:0] JMAX       = JW'(MAX_JUMPS);

   typedef enum logic [2:0] {S_RESET, S_SETTLE, S_SEARCH, S_VERIFY, S_LOCKED} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [10:0]     sr_q, sr_d;
   logic [2:0]      ph_q, ph_d;
   logic [KW-1:0]   kc_q, kc_d;
   logic [JW-1:0]   jc_q, jc_d;
   logic            mis_q, mis_d;
   logic [1:0]      dst_q;
   logic            off_q, off_d;
   logic [9:0]      word_q, word_d;
   logic            wv_q, wv_d;
   logic [7:0]      retry_q, retry_d;
   logic            rstn_q, lock_q;

   logic [9:0]      cand0, cand1, cap_dat;
   logic            hit0, hit1, hit_any, al_hit, mis_hit, jump, cap;
   logic [JW-1:0]   jc_inc;
   logic [2:0]      ph_inc;

   assign cand0   = sr_q[9:0];
   assign cand1   = sr_q[10:1];
   assign hit0    = (cand0 == COMMA) || (cand0 == ~COMMA);
   assign hit1    = (cand1 == COMMA) || (cand1 == ~COMMA);
   assign hit_any = hit0 || hit1;
   assign al_hit  = (off_q ? hit1 : hit0) && (ph_q == 3'd0);
   assign mis_hit = hit_any && !al_hit;
   assign jump    = (dru_state != dst_q);
   assign jc_inc  = jc_q + JW'(jump);
   assign ph_inc  = (ph_q == 3'd4) ? 3'd0 : ph_q + 3'd1;
   assign sr_d    = {sr_q[8:0], dru_data[1], dru_data[0]};

   always_comb begin
      state_d = state_q;
      off_d   = off_q;
      ph_d    = ph_q;
      kc_d    = kc_q;
      jc_d    = jc_q;
      mis_d   = mis_q;
      cap     = 1'b0;
      cap_dat = off_q ? cand1 : cand0;
      case (state_q)
         S_RESET:  if (cnt_q == HOLD_END) state_d = S_SETTLE;
         S_SETTLE: if (cnt_q == SETTLE_END) state_d = S_SEARCH;
         S_SEARCH: begin
            if (hit_any) begin
               // The comma cycle itself is word phase 0, so the next cycle is phase 1.
               state_d = S_VERIFY;
               off_d   = !hit0;
               ph_d    = 3'd1;
               kc_d    = KW'(1);
               cap     = 1'b1;
               cap_dat = hit0 ? cand0 : cand1;
            end else if (cnt_q == TMO_END) begin
               state_d = S_RESET;
            end
         end
         S_VERIFY: begin
            ph_d = ph_inc;
            cap  = (ph_q == 3'd0);
            if (al_hit) begin
               kc_d = kc_q + KW'(1);
               if (kc_q + KW'(1) == LOCK_N) begin
                  state_d = S_LOCKED;
                  jc_d    = '0;
                  mis_d   = 1'b0;
               end
            end else if (hit_any) begin
               state_d = S_SEARCH;
            end else if (cnt_q == TMO_END) begin
               state_d = S_RESET;
            end
         end
         S_LOCKED: begin
            ph_d = ph_inc;
            cap  = (ph_q == 3'd0);
            if (jc_inc > JMAX) begin
               state_d = S_RESET;
            end else begin
               jc_d = (cnt_q == WIN_END) ? '0 : jc_inc;
               if (al_hit) begin
                  mis_d = 1'b0;
               end else if (mis_hit) begin
                  if (mis_q) state_d = S_SEARCH;
                  else       mis_d   = 1'b1;
               end
            end
         end
         default: state_d = S_RESET;
      endcase
      if (!enable) state_d = S_RESET;

      if ((state_d != state_q) || (state_q == S_RESET && !enable) ||
          (state_q == S_LOCKED && cnt_q == WIN_END))
         cnt_d = '0;
      else
         cnt_d = cnt_q + CW'(1);

      // A word decided in the cycle we leave the aligned states is dropped.
      wv_d    = cap && (state_d == S_VERIFY || state_d == S_LOCKED);
      word_d  = wv_d ? cap_dat : word_q;
      retry_d = retry_q;
      if (state_d == S_RESET && state_q != S_RESET && retry_q != 8'hFF)
         retry_d = retry_q + 8'd1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_RESET;
         cnt_q   <= '0;
         sr_q    <= '0;
         ph_q    <= '0;
         kc_q    <= '0;
         jc_q    <= '0;
         mis_q   <= 1'b0;
         dst_q   <= '0;
         off_q   <= 1'b0;
         word_q  <= '0;
         wv_q    <= 1'b0;
         retry_q <= '0;
         rstn_q  <= 1'b0;
         lock_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sr_q    <= sr_d;
         ph_q    <= ph_d;
         kc_q    <= kc_d;
         jc_q    <= jc_d;
         mis_q   <= mis_d;
         dst_q   <= dru_state;
         off_q   <= off_d;
         word_q  <= word_d;
         wv_q    <= wv_d;
         retry_q <= retry_d;
         rstn_q  <= (state_d != S_RESET);
         lock_q  <= (state_d == S_LOCKED);
      end
   end

   assign dru_aresetn = rstn_q;
   assign word        = word_q;
   assign word_valid  = wv_q;
   assign locked      = lock_q;
   assign bit_offset  = off_q;
   assign retry_count = retry_q;

endmodule

// File: tb/tb_dru_align_ctrl.sv
// Directed bench for dru_align_ctrl: serial symbol stream with K28.5 every 10th symbol.
module tb_dru_align_ctrl;
   localparam logic [9:0] K285 = 10'b0011111010;

   logic       clk = 1'b0;
   logic       reset, enable;
   logic [1:0] dru_data, dru_state;
   logic       dru_aresetn, word_valid, locked, bit_offset;
   logic [9:0] word;
   logic [7:0] retry_count;

   always #5 clk = ~clk;

   dru_align_ctrl dut (
      .clk(clk), .reset(reset), .enable(enable),
      .dru_data(dru_data), .dru_state(dru_state),
      .dru_aresetn(dru_aresetn), .word(word), .word_valid(word_valid),
      .locked(locked), .bit_offset(bit_offset), .retry_count(retry_count)
   );

   int nerr = 0, nchk = 0, cyc = 0, bp = 0, exp_prev = -1;
   bit zero_mode = 1'b0, word_chk = 1'b0;

   function automatic logic [9:0] sym(input int n);
      if (n % 10 == 0) return K285;
      return (n % 2 == 1) ? 10'h155 : 10'h2AA;
   endfunction

   function automatic logic sbit(input int p);
      logic [9:0] s;
      if (p < 0) return 1'b0;
      s = sym(p / 10);
      return s[9 - (p % 10)];
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nchk++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   // One clock: drive two stream bits (earlier bit on [1]), sample #1 after the edge.
   task automatic tick();
      int done;
      done = -1;
      if (zero_mode) dru_data = 2'b00;
      else           dru_data = {sbit(bp), sbit(bp + 1)};
      if (!zero_mode && (bp % 10 == 8 || bp % 10 == 9)) done = bp / 10;
      bp += 2;
      @(posedge clk);
      #1;
      cyc++;
      if (word_chk && word_valid) begin
         if (exp_prev < 0) check("word_phase", 32'(word_valid), 0);
         else              check("word", 32'(word), 32'(sym(exp_prev)));
      end
      exp_prev = done;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic wait_lock(input int max_t, input string tag);
      int n;
      n = 0;
      while (!locked && n < max_t) begin
         tick();
         n++;
      end
      check(tag, 32'(locked), 1);
   endtask

   task automatic check_cleared(input string tag);
      check({tag, "_rstn"},  32'(dru_aresetn), 0);
      check({tag, "_word"},  32'(word), 0);
      check({tag, "_wv"},    32'(word_valid), 0);
      check({tag, "_lock"},  32'(locked), 0);
      check({tag, "_off"},   32'(bit_offset), 0);
      check({tag, "_retry"}, 32'(retry_count), 0);
   endtask

   initial begin
      int n, ncomma, lock_cyc, last_wv, npulse, t0;
      reset = 1'b1; enable = 1'b1; dru_state = 2'b00; dru_data = 2'b00;
      ticks(2);
      check_cleared("por");
      reset = 1'b0;

      // Scenario 1: hold, settle, lock at offset 0
      ticks(15);
      check("hold_15", 32'(dru_aresetn), 0);
      tick();
      check("hold_16", 32'(dru_aresetn), 1);
      word_chk = 1'b1;
      ncomma = 0; n = 0;
      while (!locked && n < 600) begin
         tick();
         n++;
         if (word_valid && word == K285) ncomma++;
      end
      check("s1_lock", 32'(locked), 1);
      check("s1_commas", 32'(ncomma), 4);
      check("s1_off", 32'(bit_offset), 0);
      check("s1_retry", 32'(retry_count), 0);
      lock_cyc = cyc;
      last_wv = -1; npulse = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (word_valid) begin
            if (last_wv >= 0) check("wv_period", 32'(cyc - last_wv), 5);
            last_wv = cyc;
            npulse++;
         end
      end
      check("wv_count", 32'(npulse), 4);

      // Scenario 4: 8 jumps tolerated, 9 in one window restart the DRU
      for (int i = 0; i < 8; i++) begin
         dru_state = ~dru_state;
         tick();
      end
      check("jump8_keep", 32'(locked), 1);
      while (cyc < lock_cyc + 267) tick();
      check("jump8_window", 32'(locked), 1);
      for (int i = 0; i < 8; i++) begin
         dru_state = ~dru_state;
         tick();
      end
      check("jump9_pre", 32'(locked), 1);
      dru_state = ~dru_state;
      tick();
      check("jump9_unlock", 32'(locked), 0);
      check("jump9_rstn", 32'(dru_aresetn), 0);
      check("jump9_retry", 32'(retry_count), 1);
      wait_lock(600, "s4_relock");
      check("s4_off", 32'(bit_offset), 0);

      // Scenario 5: one-bit slip right after a comma word
      n = 0;
      while (!(word_valid && word == K285) && n < 100) begin
         tick();
         n++;
      end
      check("s5_sync", 32'(word_valid), 1);
      word_chk = 1'b0;
      bp += 1;
      ticks(75);
      check("slip_first_keep", 32'(locked), 1);
      ticks(50);
      check("slip_second_search", 32'(locked), 0);
      check("slip_no_restart", 32'(dru_aresetn), 1);
      check("slip_retry", 32'(retry_count), 1);
      wait_lock(400, "s5_relock");
      check("s5_off", 32'(bit_offset), 1);
      word_chk = 1'b1;
      ticks(30);

      // Scenario 6: enable drop, then reset, while locked
      enable = 1'b0;
      tick();
      check("en_unlock", 32'(locked), 0);
      check("en_rstn", 32'(dru_aresetn), 0);
      check("en_wv", 32'(word_valid), 0);
      check("en_retry", 32'(retry_count), 2);
      ticks(5);
      check("en_retry_once", 32'(retry_count), 2);
      check("en_hold_rstn", 32'(dru_aresetn), 0);
      enable = 1'b1;
      wait_lock(600, "s6_relock");
      check("s6_off", 32'(bit_offset), 1);
      reset = 1'b1;
      tick();
      check_cleared("mid_rst");

      // Scenario 3: no comma, repeated search timeouts
      zero_mode = 1'b1;
      word_chk = 1'b0;
      tick();
      reset = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         n = 0;
         while (!dru_aresetn && n < 100) begin
            tick();
            n++;
         end
         check("s3_rise", 32'(dru_aresetn), 1);
         t0 = cyc;
         n = 0;
         while (dru_aresetn && n < 1200) begin
            tick();
            n++;
         end
         check("s3_settle_search_len", 32'(cyc - t0), 1088);
         check("s3_retry", 32'(retry_count), 32'(k));
      end

      // Scenario 2: stream shifted by one bit from the start
      reset = 1'b1;
      zero_mode = 1'b0;
      bp = 1;
      exp_prev = -1;
      ticks(2);
      reset = 1'b0;
      check("s2_retry", 32'(retry_count), 0);
      word_chk = 1'b1;
      wait_lock(600, "s2_lock");
      check("s2_off", 32'(bit_offset), 1);
      ticks(30);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule

// File: doc/dru_align_ctrl.md
DRU_ALIGN_CTRL -- requirements
Module: dru_align_ctrl

Interface
REQ-001 Parameter HOLD_CYCLES, default 16: cycles dru_aresetn is held low per restart.
REQ-002 Parameter SETTLE_CYCLES, default 64: cycles waited after DRU release before comma search.
REQ-003 Parameter COMMA, default 10'b0011111010: K28.5 RD- pattern; ~COMMA (RD+) also matches.
REQ-004 Parameter LOCK_COMMAS, default 4: aligned commas required to declare lock.
REQ-005 Parameter TIMEOUT, default 1024: max cycles in SEARCH or VERIFY before restart.
REQ-006 Parameter WINDOW, default 256: phase-jump monitoring window, in cycles.
REQ-007 Parameter MAX_JUMPS, default 8: DRU phase changes tolerated per WINDOW while locked.
REQ-008 clk  in  1  sole clock; one clock, reset is synchronous and active-high.
REQ-009 reset  in  1  synchronous, active-high reset.
REQ-010 enable  in  1  high = run; low = restart and hold in RESET.
REQ-011 dru_data  in  2  DRU recovered bits; bit[1] is the earlier bit.
REQ-012 dru_state  in  2  DRU phase-select state.
REQ-013 dru_aresetn  out  1  active-low reset driven to the DRU.
REQ-014 word  out  10  aligned word; bit[9] is the earliest bit.
REQ-015 word_valid  out  1  one-cycle strobe per word.
REQ-016 locked  out  1  high only in state LOCKED.
REQ-017 bit_offset  out  1  selected alignment (0 or 1).
REQ-018 retry_count  out  8  number of restarts, saturating at 255.

Function
REQ-019 Shift register sr[10:0] SHALL update every cycle as {sr[8:0], dru_data[1], dru_data[0]}.
REQ-020 Candidates: offset 0 = sr[9:0]; offset 1 = sr[10:1]; a hit = candidate equal to COMMA or ~COMMA; offset 0 wins on a double hit.
REQ-021 States: RESET, SETTLE, SEARCH, VERIFY, LOCKED; a single cycle counter serves as hold, settle, timeout and window counter, cleared on every state entry.
REQ-022 RESET: dru_aresetn=0; after HOLD_CYCLES cycles with enable=1 -> SETTLE.
REQ-023 SETTLE: dru_aresetn=1; after SETTLE_CYCLES cycles -> SEARCH.
REQ-024 SEARCH: on a hit, latch bit_offset, zero the mod-5 word phase counter, capture the comma word -> VERIFY (comma count=1); after TIMEOUT cycles without a hit -> RESET.
REQ-025 Word emission, VERIFY and LOCKED only: when the phase counter equals 0, word takes the candidate at bit_offset and word_valid pulses the following cycle; the phase counter then increments mod 5.
REQ-026 VERIFY: a hit at bit_offset at phase 0 increments the comma count; reaching LOCK_COMMAS -> LOCKED; a hit at any other offset or phase -> SEARCH; TIMEOUT -> RESET.
REQ-027 LOCKED: a jump = dru_state differing from its previous-cycle value; more than MAX_JUMPS jumps within one WINDOW -> RESET; the jump count clears at each window end.
REQ-028 LOCKED: two consecutive misaligned hits (wrong offset or phase) -> SEARCH; an aligned hit clears the misaligned count.
REQ-029 Every entry into RESET from any other state SHALL increment retry_count, saturating at 255.
REQ-030 enable=0 in any state: next state is RESET and the state is held there; the retry_count increment applies once.
REQ-031 Leaving VERIFY or LOCKED SHALL stop word_valid from the next cycle; no partial word is emitted.

Reset
REQ-032 When reset=1, the block SHALL take state RESET and dru_aresetn=0.
REQ-033 When reset=1, the block SHALL clear word=0, word_valid=0, locked=0, bit_offset=0 and retry_count=0.
REQ-034 When reset=1, the block SHALL clear sr, all counters and the previous dru_state.
REQ-035 Reset SHALL override enable and all other inputs.
REQ-036 Reset entry SHALL NOT increment retry_count.

Verification
REQ-037 Scenario 1 (lock): reset 2 cycles, enable=1, K28.5 every 10 words at offset 0 -> dru_aresetn high after 16 cycles; locked after the 4th comma; word_valid strobes every 5 cycles.
REQ-038 Scenario 2 (odd alignment): stream shifted by one bit -> bit_offset=1 and the emitted words equal the transmitted 10-bit symbols.
REQ-039 Scenario 3 (no comma): all-zero data -> RESET after 1024 SEARCH cycles; retry_count increments 1, 2, 3 on successive timeouts.
REQ-040 Scenario 4 (phase instability): while locked, dru_state toggles 9 times in one 256-cycle window -> locked falls and dru_aresetn=0 the next cycle; with exactly 8 toggles, lock is kept.
REQ-041 Scenario 5 (realignment): while locked, insert a one-bit slip -> first misaligned comma keeps lock, second -> SEARCH, then relock at the new offset.
REQ-042 Scenario 6 (mid-operation): reset asserted while LOCKED -> all outputs zero the next cycle, retry_count=0; enable dropped while LOCKED -> RESET with retry_count+1.
